// File: rtl/shift_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_req_arbiter
// Brief    : Shares one external fixed-latency pipelined right shifter among
//            NUM_REQ valid/ready requesters. A valid+ID tag pipe follows the
//            shifter, and results are captured in a response FIFO. Issue is
//            credit-limited (in-flight + queued < FIFO_DEPTH), so the
//            non-stallable shifter can never overflow the FIFO.
// Config   : SHIFT_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins)
//            instead of round-robin; the round-robin pointer is removed.
// Revision : 1.0 - initial release
// ============================================================================
module shift_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 13,
    parameter int STAGES     = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int SW        = $clog2(WIDTH),
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SW-1:0]    req_shift,
    output logic [WIDTH-1:0]         sh_in,
    output logic [SW-1:0]            sh_shift,
    input  logic [WIDTH-1:0]         sh_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + STAGES + 1);
    localparam int EW   = WIDTH + IDW;

    logic [CNTW-1:0]            inflight_q, inflight_d;
    logic [CNTW-1:0]            count_q, count_d;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [STAGES-1:0]          tag_v_q;
    logic [STAGES-1:0][IDW-1:0] tag_id_q;
    logic [EW-1:0]              mem_q [FIFO_DEPTH];

    logic                       credit_ok;
    logic                       found;
    logic                       grant;
    logic                       push;
    logic                       pop;
    logic [IDW-1:0]             winner;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
`else
    logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
`endif

    // Credit uses only registered counts: a pop this cycle frees credit next cycle.
    assign credit_ok = (inflight_q + count_q) < CNTW'(FIFO_DEPTH);
    assign grant     = found & credit_ok & ~reset;
    assign push      = tag_v_q[STAGES-1];
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign busy      = (inflight_q != '0) | rsp_valid;
    assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign rsp_id    = rsp_valid ? mem_q[rd_ptr_q][EW-1:WIDTH] : '0;

    // Pick the first valid requester, searching upward from the start index.
    always_comb begin : p_arb
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
`endif
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Grant decode and shifter operand mux; operands are zero when idle.
    always_comb begin
        req_ready = '0;
        sh_in     = '0;
        sh_shift  = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
            sh_in             = req_data[int'(winner)*WIDTH +: WIDTH];
            sh_shift          = req_shift[int'(winner)*SW +: SW];
        end
    end

    // Counter next-state: in-flight follows issue/exit, FIFO count follows push/pop.
    always_comb begin
        inflight_d = inflight_q + CNTW'(grant) - CNTW'(push);
        count_d    = count_q + CNTW'(push) - CNTW'(pop);
    end

    // Tag pipe, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            tag_v_q[0]  <= grant;
            tag_id_q[0] <= grant ? winner : '0;
            for (int s = 1; s < STAGES; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {tag_id_q[STAGES-1], sh_out};
        end
    end

`ifdef SHIFT_ARB_FIXED_PRIO_EN
`else
    // Round-robin pointer moves just past the winner on every handshake.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_req_arbiter
// Brief    : Self-checking bench for shift_req_arbiter with a pipelined
//            shifter model and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_req_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int WIDTH      = 13;
    localparam int STAGES     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int SW         = $clog2(WIDTH);
    localparam int IDW        = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ*SW-1:0]    req_shift = '0;
    logic [WIDTH-1:0]         sh_in;
    logic [SW-1:0]            sh_shift;
    logic [WIDTH-1:0]         sh_out;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [WIDTH-1:0]         rsp_data;
    logic [IDW-1:0]           rsp_id;
    logic                     busy;

    int n_tests = 0;
    int n_fail  = 0;

    shift_req_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_shift(req_shift),
        .sh_in    (sh_in),
        .sh_shift (sh_shift),
        .sh_out   (sh_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // External pipelined shifter, sharing the arbiter's reset.
    logic [WIDTH-1:0] shp [STAGES];
    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) shp[s] <= '0;
        end else begin
            shp[0] <= sh_in >> sh_shift;
            for (int s = 1; s < STAGES; s++) shp[s] <= shp[s-1];
        end
    end
    assign sh_out = shp[STAGES-1];

    // ---------------- reference model ----------------
    typedef struct {
        logic [WIDTH-1:0] data;
        int               id;
        int               issue;
    } item_t;

    item_t            q[$];
    int               cyc = 0;
    int               rr = 0;
    int               exp_win = -1;
    logic             exp_pop = 1'b0;
    logic [NUM_REQ-1:0] exp_ready = '0;
    logic [WIDTH-1:0] exp_sh_in = '0;
    logic [SW-1:0]    exp_sh_shift = '0;
    logic             exp_valid = 1'b0;
    logic [WIDTH-1:0] exp_data = '0;
    logic [IDW-1:0]   exp_id = '0;
    logic             exp_busy = 1'b0;

    // Expected outputs of the current cycle (inputs stable, called at negedge).
    task automatic model_eval();
        int start;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = rr;
`endif
        exp_win = -1;
        if (!reset && q.size() < FIFO_DEPTH) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_win < 0 && req_valid[(start + i) % NUM_REQ]) exp_win = (start + i) % NUM_REQ;
            end
        end
        exp_ready = '0; exp_sh_in = '0; exp_sh_shift = '0;
        if (exp_win >= 0) begin
            exp_ready[exp_win] = 1'b1;
            exp_sh_in    = req_data[exp_win*WIDTH +: WIDTH];
            exp_sh_shift = req_shift[exp_win*SW +: SW];
        end
        exp_valid = 1'b0;
        if (q.size() > 0) begin
            if (cyc >= q[0].issue + STAGES + 1) exp_valid = 1'b1;
        end
        exp_data = '0; exp_id = '0;
        if (exp_valid) begin
            exp_data = q[0].data;
            exp_id   = IDW'(q[0].id);
        end
        exp_busy = (q.size() > 0);
        exp_pop  = exp_valid && rsp_ready;
    endtask

    // Clock edge, then apply this cycle's model transitions.
    task automatic advance();
        item_t it;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            rr = 0;
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_win >= 0) begin
                it.data  = exp_sh_in >> exp_sh_shift;
                it.id    = exp_win;
                it.issue = cyc;
                q.push_back(it);
                rr = (exp_win + 1) % NUM_REQ;
            end
        end
        cyc++;
    endtask

    task automatic set_lane(input int r, input logic v, input logic [WIDTH-1:0] d, input logic [SW-1:0] s);
        req_valid[r] = v;
        req_data[r*WIDTH +: WIDTH] = d;
        req_shift[r*SW +: SW] = s;
    endtask

    task automatic rand_lanes();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data[r*WIDTH +: WIDTH] = WIDTH'($urandom);
            req_shift[r*SW +: SW] = SW'($urandom);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(negedge clk); model_eval(); advance();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req_valid = '1; rsp_ready = 1'b0;
        advance(); advance();
        @(negedge clk); model_eval();
        n_tests++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready);
        end
        n_tests++;
        if ({rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b d=%h id=%0d busy=%b want all 0", rsp_valid, rsp_data, rsp_id, busy);
        end
        advance();
        reset = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        int acc = -1;
        bit seen = 0;
        rsp_ready = 1'b1;
        set_lane(0, 1'b1, 13'h1FFF, 4'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({req_ready, sh_in, sh_shift} !== {exp_ready, exp_sh_in, exp_sh_shift}) begin
                n_fail++; $display("FAIL single_issue cyc=%0d: got %b/%h/%0d want %b/%h/%0d", cyc, req_ready, sh_in, sh_shift, exp_ready, exp_sh_in, exp_sh_shift);
            end
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_id, busy} !== {exp_valid, exp_data, exp_id, exp_busy}) begin
                n_fail++; $display("FAIL single_rsp cyc=%0d: got v=%b d=%h id=%0d b=%b want v=%b d=%h id=%0d b=%b", cyc, rsp_valid, rsp_data, rsp_id, busy, exp_valid, exp_data, exp_id, exp_busy);
            end
            if (req_valid[0] && req_ready[0]) acc = cyc;
            if (rsp_valid && !seen) begin
                seen = 1;
                n_tests++;
                if (cyc - acc != STAGES + 1 || rsp_data !== 13'h01FF || rsp_id !== '0) begin
                    n_fail++; $display("FAIL single_latency: got lat=%0d d=%h id=%0d want lat=%0d d=01ff id=0", cyc - acc, rsp_data, rsp_id, STAGES + 1);
                end
            end
            advance();
            if (exp_win == 0) req_valid[0] = 1'b0;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL single_seen: got no response want one");
        end
    endtask

    task automatic test_round_robin();
        int last = -1;
        int g;
        drain();
        rsp_ready = 1'b1;
        req_valid = '1;
        rand_lanes();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({req_ready, sh_in, sh_shift} !== {exp_ready, exp_sh_in, exp_sh_shift}) begin
                n_fail++; $display("FAIL rr_issue cyc=%0d: got %b/%h/%0d want %b/%h/%0d", cyc, req_ready, sh_in, sh_shift, exp_ready, exp_sh_in, exp_sh_shift);
            end
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_id, busy} !== {exp_valid, exp_data, exp_id, exp_busy}) begin
                n_fail++; $display("FAIL rr_rsp cyc=%0d: got v=%b d=%h id=%0d b=%b want v=%b d=%h id=%0d b=%b", cyc, rsp_valid, rsp_data, rsp_id, busy, exp_valid, exp_data, exp_id, exp_busy);
            end
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            if (req_ready != '0) begin
                g = 0;
                for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) g = r;
                if (last >= 0) begin
                    n_tests++;
                    if (g != (last + 1) % NUM_REQ) begin
                        n_fail++; $display("FAIL rr_order: got grant %0d want %0d", g, (last + 1) % NUM_REQ);
                    end
                end
                last = g;
            end
`endif
            advance();
            rand_lanes();
        end
    endtask

    task automatic test_backpressure();
        int nacc = 0;
        int nres = 0;
        drain();
        rsp_ready = 1'b0;
        req_valid = '0;
        set_lane(1, 1'b1, WIDTH'($urandom), SW'($urandom));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({req_ready, sh_in, sh_shift} !== {exp_ready, exp_sh_in, exp_sh_shift}) begin
                n_fail++; $display("FAIL bp_issue cyc=%0d: got %b/%h/%0d want %b/%h/%0d", cyc, req_ready, sh_in, sh_shift, exp_ready, exp_sh_in, exp_sh_shift);
            end
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_id, busy} !== {exp_valid, exp_data, exp_id, exp_busy}) begin
                n_fail++; $display("FAIL bp_rsp cyc=%0d: got v=%b d=%h id=%0d b=%b want v=%b d=%h id=%0d b=%b", cyc, rsp_valid, rsp_data, rsp_id, busy, exp_valid, exp_data, exp_id, exp_busy);
            end
            if (req_valid[1] && req_ready[1]) nacc++;
            advance();
            set_lane(1, 1'b1, WIDTH'($urandom), SW'($urandom));
        end
        n_tests++;
        if (nacc != FIFO_DEPTH) begin
            n_fail++; $display("FAIL bp_accepts: got %0d want %0d", nacc, FIFO_DEPTH);
        end
        rsp_ready = 1'b1;
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({req_ready, sh_in, sh_shift} !== {exp_ready, exp_sh_in, exp_sh_shift}) begin
                n_fail++; $display("FAIL bpd_issue cyc=%0d: got %b/%h/%0d want %b/%h/%0d", cyc, req_ready, sh_in, sh_shift, exp_ready, exp_sh_in, exp_sh_shift);
            end
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_id, busy} !== {exp_valid, exp_data, exp_id, exp_busy}) begin
                n_fail++; $display("FAIL bpd_rsp cyc=%0d: got v=%b d=%h id=%0d b=%b want v=%b d=%h id=%0d b=%b", cyc, rsp_valid, rsp_data, rsp_id, busy, exp_valid, exp_data, exp_id, exp_busy);
            end
            if (rsp_valid && nres < FIFO_DEPTH) begin
                nres++;
                n_tests++;
                if (rsp_id !== IDW'(1)) begin
                    n_fail++; $display("FAIL bp_drain_id: got %0d want 1", rsp_id);
                end
            end
            if (req_valid[1] && req_ready[1]) nacc++;
            advance();
            set_lane(1, 1'b1, WIDTH'($urandom), SW'($urandom));
        end
        n_tests++;
        if (nres != FIFO_DEPTH || nacc == 0) begin
            n_fail++; $display("FAIL bp_resume: got drained=%0d accepts=%0d want drained=%0d accepts>0", nres, nacc, FIFO_DEPTH);
        end
    endtask

    task automatic test_boundary();
        int nwin = 0;
        int nres = 0;
        logic [WIDTH-1:0] res [2];
        res[0] = '0; res[1] = '0;
        drain();
        rsp_ready = 1'b1;
        set_lane(2, 1'b1, 13'h1000, 4'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({req_ready, sh_in, sh_shift} !== {exp_ready, exp_sh_in, exp_sh_shift}) begin
                n_fail++; $display("FAIL bnd_issue cyc=%0d: got %b/%h/%0d want %b/%h/%0d", cyc, req_ready, sh_in, sh_shift, exp_ready, exp_sh_in, exp_sh_shift);
            end
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_id, busy} !== {exp_valid, exp_data, exp_id, exp_busy}) begin
                n_fail++; $display("FAIL bnd_rsp cyc=%0d: got v=%b d=%h id=%0d b=%b want v=%b d=%h id=%0d b=%b", cyc, rsp_valid, rsp_data, rsp_id, busy, exp_valid, exp_data, exp_id, exp_busy);
            end
            if (rsp_valid && nres < 2) begin
                res[nres] = rsp_data;
                nres++;
            end
            advance();
            if (exp_win == 2) begin
                nwin++;
                if (nwin == 1) req_shift[2*SW +: SW] = 4'd12;
                else req_valid[2] = 1'b0;
            end
        end
        n_tests++;
        if (nres != 2 || res[0] !== 13'h1000 || res[1] !== 13'h0001) begin
            n_fail++; $display("FAIL bnd_values: got n=%0d %h %h want 2 1000 0001", nres, res[0], res[1]);
        end
    endtask

    task automatic test_reset_mid();
        int nacc = 0;
        drain();
        rsp_ready = 1'b0;
        set_lane(3, 1'b1, WIDTH'($urandom), SW'($urandom));
        for (int c = 0; c < 10 && nacc < FIFO_DEPTH; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_id, busy} !== {exp_valid, exp_data, exp_id, exp_busy}) begin
                n_fail++; $display("FAIL rm_fill cyc=%0d: got v=%b d=%h id=%0d b=%b want v=%b d=%h id=%0d b=%b", cyc, rsp_valid, rsp_data, rsp_id, busy, exp_valid, exp_data, exp_id, exp_busy);
            end
            advance();
            if (exp_win == 3) nacc++;
        end
        n_tests++;
        if (nacc != FIFO_DEPTH) begin
            n_fail++; $display("FAIL rm_accepts: got %0d want %0d", nacc, FIFO_DEPTH);
        end
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk); model_eval(); advance();
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk); model_eval();
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rm_after_reset: got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
        advance();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({rsp_valid, busy} !== 2'b00) begin
                n_fail++; $display("FAIL rm_stale cyc=%0d: got v=%b busy=%b want 0 0", cyc, rsp_valid, busy);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({req_ready, sh_in, sh_shift} !== {exp_ready, exp_sh_in, exp_sh_shift}) begin
                n_fail++; $display("FAIL rnd_issue cyc=%0d: got %b/%h/%0d want %b/%h/%0d", cyc, req_ready, sh_in, sh_shift, exp_ready, exp_sh_in, exp_sh_shift);
            end
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_id, busy} !== {exp_valid, exp_data, exp_id, exp_busy}) begin
                n_fail++; $display("FAIL rnd_rsp cyc=%0d: got v=%b d=%h id=%0d b=%b want v=%b d=%h id=%0d b=%b", cyc, rsp_valid, rsp_data, rsp_id, busy, exp_valid, exp_data, exp_id, exp_busy);
            end
            advance();
            req_valid = NUM_REQ'($urandom);
            rand_lanes();
            if ((c / 50) % 2 == 0) rsp_ready = ($urandom_range(0, 3) != 0);
            else rsp_ready = ($urandom_range(0, 3) == 0);
        end
    endtask

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        drain();
        rsp_ready = 1'b1;
        req_valid = '0;
        set_lane(0, 1'b1, WIDTH'($urandom), SW'($urandom));
        set_lane(2, 1'b1, WIDTH'($urandom), SW'($urandom));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if ({req_ready, sh_in, sh_shift} !== {exp_ready, exp_sh_in, exp_sh_shift}) begin
                n_fail++; $display("FAIL fp_issue cyc=%0d: got %b/%h/%0d want %b/%h/%0d", cyc, req_ready, sh_in, sh_shift, exp_ready, exp_sh_in, exp_sh_shift);
            end
            n_tests++;
            if (req_ready[2] !== 1'b0) begin
                n_fail++; $display("FAIL fp_starve cyc=%0d: got ready2=%b want 0", cyc, req_ready[2]);
            end
            advance();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        test_random();
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
